// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit bimodal predictor with misprediction redirect and
// saturating branch / misprediction statistics.
module branch_predict_unit #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_bran,
  input  logic [2:0]       ex_cond,
  input  logic [2:0]       ex_flag,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred,
  output logic             take_bran,
  output logic             mispred,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] bran_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             resolve;
  logic             wrong;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
  assign flag_z = ex_flag[2];
  assign flag_v = ex_flag[1];
  assign flag_n = ex_flag[0];

  // Lookup reads the pre-update entry; no same-cycle bypass from the resolve path.
  assign pred_taken = pht[rd_idx][1];

  always_comb begin
    take_bran = 1'b0;
    if (ex_valid && ex_bran) begin
      case (ex_cond)
        3'b000:  take_bran = flag_z;
        3'b001:  take_bran = !flag_z;
        3'b010:  take_bran = !flag_z && !flag_n;
        3'b011:  take_bran = flag_n;
        3'b100:  take_bran = flag_z || !flag_n;
        3'b101:  take_bran = flag_z || flag_n;
        3'b110:  take_bran = flag_v;
        default: take_bran = 1'b1;
      endcase
    end
  end

  assign resolve = ex_valid && ex_bran;
  assign wrong   = resolve && (take_bran != ex_pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht[IDX_W'(i)] <= 2'b01;
      end
      mispred     <= 1'b0;
      redirect_pc <= '0;
      bran_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      mispred <= wrong;
      if (wrong) begin
        redirect_pc <= take_bran ? ex_target : ex_pc + PC_W'(4);
      end
      if (resolve) begin
        if (take_bran) begin
          if (pht[wr_idx] != 2'b11) pht[wr_idx] <= pht[wr_idx] + 2'd1;
        end else begin
          if (pht[wr_idx] != 2'b00) pht[wr_idx] <= pht[wr_idx] - 2'd1;
        end
        if (bran_cnt != '1) bran_cnt <= bran_cnt + CNT_W'(1);
      end
      if (wrong && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit against a behavioural predictor model;
// a second instance with 4-bit counters exercises statistics saturation.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic        ex_bran;
  logic [2:0]  ex_cond;
  logic [2:0]  ex_flag;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred;

  logic        pred_taken, take_bran, mispred;
  logic [31:0] redirect_pc;
  logic [15:0] bran_cnt, mispred_cnt;
  logic        pred_taken_s, take_bran_s, mispred_s;
  logic [31:0] redirect_pc_s;
  logic [3:0]  bran_cnt_s, mispred_cnt_s;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_pht [16];
  int          m_bran, m_misp, m_bran_s, m_misp_s;
  bit          m_mispred;
  logic [31:0] m_redir;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_bran(ex_bran), .ex_cond(ex_cond), .ex_flag(ex_flag),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred(ex_pred), .take_bran(take_bran),
    .mispred(mispred), .redirect_pc(redirect_pc), .bran_cnt(bran_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_predict_unit #(.PC_W(32), .IDX_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken_s),
    .ex_valid(ex_valid), .ex_bran(ex_bran), .ex_cond(ex_cond), .ex_flag(ex_flag),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred(ex_pred), .take_bran(take_bran_s),
    .mispred(mispred_s), .redirect_pc(redirect_pc_s), .bran_cnt(bran_cnt_s),
    .mispred_cnt(mispred_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_take(bit v, bit b, int cond, logic [2:0] flag);
    bit z, ov, n;
    z = flag[2]; ov = flag[1]; n = flag[0];
    if (!(v && b)) return 1'b0;
    case (cond)
      0: return z;
      1: return !z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return ov;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_pht[idx_of(pc)] >= 2;
  endfunction

  // Advance one clock edge, applying the spec rules to the model for the inputs present.
  task automatic cycle();
    bit res, t, wrong;
    int i;
    res   = !rst && ex_valid && ex_bran;
    t     = ref_take(ex_valid, ex_bran, int'(ex_cond), ex_flag);
    wrong = res && (t != ex_pred);
    i     = idx_of(ex_pc);
    if (rst) begin
      foreach (m_pht[k]) m_pht[k] = 1;
      m_mispred = 0; m_redir = 0;
      m_bran = 0; m_misp = 0; m_bran_s = 0; m_misp_s = 0;
    end else begin
      m_mispred = wrong;
      if (wrong) m_redir = t ? ex_target : ex_pc + 32'd4;
      if (res) begin
        m_pht[i] = t ? ((m_pht[i] < 3) ? m_pht[i] + 1 : 3) : ((m_pht[i] > 0) ? m_pht[i] - 1 : 0);
        m_bran   = (m_bran < 65535) ? m_bran + 1 : 65535;
        m_bran_s = (m_bran_s < 15) ? m_bran_s + 1 : 15;
      end
      if (wrong) begin
        m_misp   = (m_misp < 65535) ? m_misp + 1 : 65535;
        m_misp_s = (m_misp_s < 15) ? m_misp_s + 1 : 15;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; ex_valid = 0; ex_bran = 0; ex_cond = 0; ex_flag = 0;
    ex_pc = 0; ex_target = 0; ex_pred = 0; if_pc = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mispred !== 1'b0) begin errors++; $display("FAIL reset_mispred got %0b exp 0", mispred); end
    checks++;
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %0h exp 0", redirect_pc); end
    checks++;
    if (bran_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bran_cnt, mispred_cnt);
    end
    for (int k = 0; k < 16; k++) begin
      if_pc = 32'(k * 4 + 32'h1000);
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred pc=%0h got %0b exp 0", if_pc, pred_taken); end
    end
  endtask

  task automatic test_cond_sweep();
    do_reset();
    ex_valid = 1; ex_pc = 32'h80; ex_target = 32'h90;
    for (int b = 1; b >= 0; b--) begin
      ex_bran = 1'(b);
      for (int c = 0; c < 8; c++) begin
        for (int f = 0; f < 8; f++) begin
          ex_cond = 3'(c); ex_flag = 3'(f); ex_pred = 1'($urandom);
          #1;
          checks++;
          if (take_bran !== ref_take(1'b1, 1'(b), c, 3'(f))) begin
            errors++;
            $display("FAIL cond bran=%0d cond=%0d flag=%0d got %0b exp %0b", b, c, f, take_bran,
                     ref_take(1'b1, 1'(b), c, 3'(f)));
          end
          cycle();
          checks++;
          if (mispred !== m_mispred) begin errors++; $display("FAIL cond_mispred got %0b exp %0b", mispred, m_mispred); end
        end
      end
    end
    idle();
  endtask

  task automatic test_training();
    do_reset();
    ex_valid = 1; ex_bran = 1; ex_cond = 3'b111; ex_pc = 32'h40; ex_target = 32'h400;
    ex_pred = 1; if_pc = 32'h40;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++;
      if (pred_taken !== m_pred(32'h40) || pred_taken !== 1'b1) begin
        errors++; $display("FAIL train step=%0d got %0b exp 1", n, pred_taken);
      end
    end
    ex_valid = 0;
    checks++;
    if (bran_cnt !== 16'd3) begin errors++; $display("FAIL train_cnt got %0d exp 3", bran_cnt); end
    // Entry is saturated at 11: two not-taken updates are needed to flip the prediction.
    ex_valid = 1; ex_cond = 3'b000; ex_flag = 3'b000; ex_pred = 1;
    cycle();
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_hyst got %0b exp 1", pred_taken); end
    cycle();
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_flip got %0b exp 0", pred_taken); end
    idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    ex_valid = 1; ex_bran = 1; ex_cond = 3'b111; ex_pc = 32'h100; ex_target = 32'h200; ex_pred = 0;
    cycle();
    ex_valid = 0;
    checks++;
    if (mispred !== 1'b1 || redirect_pc !== 32'h200) begin
      errors++; $display("FAIL misp_taken got %0b/%0h exp 1/200", mispred, redirect_pc);
    end
    cycle();
    checks++;
    if (mispred !== 1'b0 || redirect_pc !== 32'h200) begin
      errors++; $display("FAIL misp_clear got %0b/%0h exp 0/200", mispred, redirect_pc);
    end
    ex_valid = 1; ex_cond = 3'b000; ex_flag = 3'b000; ex_pred = 1;
    cycle();
    ex_valid = 0;
    checks++;
    if (mispred !== 1'b1 || redirect_pc !== 32'h104) begin
      errors++; $display("FAIL misp_nt got %0b/%0h exp 1/104", mispred, redirect_pc);
    end
    checks++;
    if (mispred_cnt !== 16'd2) begin errors++; $display("FAIL misp_cnt got %0d exp 2", mispred_cnt); end
    // Wrap-around of the fall-through address.
    ex_valid = 1; ex_pc = 32'hFFFF_FFFC;
    cycle();
    ex_valid = 0;
    checks++;
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL misp_wrap got %0h exp 0", redirect_pc); end
    cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_valid = 1; ex_bran = 1; ex_cond = 3'b111; ex_pred = 0;
    for (int n = 0; n < 4; n++) begin
      ex_pc = 32'(32'h300 + n * 16); ex_target = 32'(32'h7000 + n * 8);
      cycle();
      checks++;
      if (mispred !== 1'b1 || redirect_pc !== 32'(32'h7000 + n * 8)) begin
        errors++; $display("FAIL b2b n=%0d got %0b/%0h exp 1/%0h", n, mispred, redirect_pc, 32'h7000 + n * 8);
      end
    end
    ex_valid = 0;
    cycle();
    checks++;
    if (mispred !== 1'b0 || mispred_cnt !== 16'd4) begin
      errors++; $display("FAIL b2b_end got %0b/%0d exp 0/4", mispred, mispred_cnt);
    end
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    ex_valid = 1; ex_bran = 1; ex_cond = 3'b111; ex_pc = 32'h48; if_pc = 32'h48; ex_pred = 1;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL collide_same got %0b exp 0", pred_taken); end
    cycle();
    ex_valid = 0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL collide_next got %0b exp 1", pred_taken); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ex_valid = 1; ex_bran = 1; ex_cond = 3'b111; ex_pc = 32'h48; ex_target = 32'h900; ex_pred = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0; ex_valid = 0; if_pc = 32'h48;
    #1;
    checks++;
    if (mispred !== 1'b0) begin errors++; $display("FAIL rstmid_mispred got %0b exp 0", mispred); end
    checks++;
    if (bran_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
      errors++; $display("FAIL rstmid_counts got %0d/%0d exp 0/0", bran_cnt, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_pred got %0b exp 0", pred_taken); end
    // One taken update from 01 must reach 10.
    ex_valid = 1; ex_pred = 1;
    cycle();
    ex_valid = 0;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL rstmid_entry got %0b exp 1", pred_taken); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_bran = 1; ex_cond = 3'b111; ex_pred = 0;
    for (int n = 0; n < 19; n++) begin
      ex_valid = (n % 10 == 4) ? 1'b0 : 1'b1;
      ex_pc = 32'(n * 4);
      cycle();
    end
    idle();
    checks++;
    if (bran_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_bran4 got %0d exp 15", bran_cnt_s); end
    checks++;
    if (mispred_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_misp4 got %0d exp 15", mispred_cnt_s); end
    checks++;
    if (bran_cnt !== 16'd17) begin errors++; $display("FAIL sat_bran16 got %0d exp 17", bran_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      ex_valid  = 1'($urandom);
      ex_bran   = ($urandom_range(0, 3) != 0);
      ex_cond   = 3'($urandom);
      ex_flag   = 3'($urandom);
      ex_pc     = {$urandom_range(0, 1) == 0 ? 24'h0 : 24'hFFFFFF, 6'($urandom), 2'b00};
      ex_target = $urandom;
      ex_pred   = 1'($urandom);
      if_pc     = {26'($urandom), 4'($urandom), 2'b00};
      #1;
      checks++;
      if (take_bran !== ref_take(ex_valid, ex_bran, int'(ex_cond), ex_flag)) begin
        errors++; $display("FAIL rnd_take n=%0d got %0b", n, take_bran);
      end
      checks++;
      if (pred_taken !== m_pred(if_pc)) begin
        errors++; $display("FAIL rnd_pred n=%0d got %0b exp %0b", n, pred_taken, m_pred(if_pc));
      end
      cycle();
      checks++;
      if (mispred !== m_mispred || redirect_pc !== m_redir) begin
        errors++; $display("FAIL rnd_redirect n=%0d got %0b/%0h exp %0b/%0h", n, mispred, redirect_pc, m_mispred, m_redir);
      end
      checks++;
      if (bran_cnt !== 16'(m_bran) || mispred_cnt !== 16'(m_misp) ||
          bran_cnt_s !== 4'(m_bran_s) || mispred_cnt_s !== 4'(m_misp_s)) begin
        errors++; $display("FAIL rnd_counts n=%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", n,
                           bran_cnt, mispred_cnt, bran_cnt_s, mispred_cnt_s, m_bran, m_misp, m_bran_s, m_misp_s);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_cond_sweep();
    test_training();
    test_mispredict();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
